// File: rtl/distance_pkg.sv
// Shared distance types and constants for the distance filter and PWM path.
// Samples are unsigned distances in units of 10^-2 cm.
package distance_pkg;

  localparam int DIST_WIDTH     = 13;
  localparam int DIST_MAX_CM100 = 3000;  // downstream PWM stage saturates here

  typedef logic [DIST_WIDTH-1:0] distance_t;

  typedef enum logic {
    ST_FILLING = 1'b0,
    ST_RUNNING = 1'b1
  } avg_state_e;

endpackage

// File: rtl/distance_ring_buffer.sv
// Window storage for distance_averager: synchronously cleared sample array
// with a wrapping write pointer; the read port always shows the oldest entry.
module distance_ring_buffer #(
  parameter int WIDTH      = 13,
  parameter int LOG2_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_oldest
);

  localparam int DEPTH = 2 ** LOG2_DEPTH;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
      wr_ptr      <= wr_ptr + 1'b1;  // power-of-two depth wraps naturally
    end
  end

  // The slot about to be overwritten holds the sample leaving the window.
  assign rd_oldest = mem[wr_ptr];

endmodule

// File: rtl/distance_averager.sv
// Moving-average filter feeding the distance-to-PWM stage.
// Define DISTANCE_AVERAGER_ROUND_EN for round-half-up output instead of truncation.
module distance_averager
  import distance_pkg::*;
#(
  parameter int WIDTH      = DIST_WIDTH,
  parameter int LOG2_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample_in,
  output logic [WIDTH-1:0] avg_out,
  output logic             avg_valid,
  output logic             filled
);

  localparam int SW    = WIDTH + LOG2_DEPTH;
  localparam int DEPTH = 2 ** LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] CNT_FULL = (LOG2_DEPTH + 1)'(DEPTH);
  localparam logic [LOG2_DEPTH:0] CNT_LAST = (LOG2_DEPTH + 1)'(DEPTH - 1);

  logic [WIDTH-1:0]    oldest;
  logic [SW-1:0]       sum_q;
  logic [SW-1:0]       next_sum;
  logic [LOG2_DEPTH:0] cnt_q;
  logic [WIDTH-1:0]    avg_d;
  avg_state_e          state_q;
  avg_state_e          state_d;

  distance_ring_buffer #(
    .WIDTH      (WIDTH),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_ring (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (sample_valid),
    .wr_data   (sample_in),
    .rd_oldest (oldest)
  );

  // Modular arithmetic at sum width: the true result always fits, so any
  // intermediate wrap of sum+sample cancels in the subtraction.
  assign next_sum = sum_q + SW'(sample_in) - SW'(oldest);

`ifdef DISTANCE_AVERAGER_ROUND_EN
  localparam logic [SW:0] HALF = (SW + 1)'(1) << (LOG2_DEPTH - 1);
  logic [SW:0] rnd_sum;
  logic [SW:0] rnd_shift;
  assign rnd_sum   = {1'b0, next_sum} + HALF;
  assign rnd_shift = rnd_sum >> LOG2_DEPTH;
  assign avg_d     = (|rnd_shift[SW:WIDTH]) ? '1 : rnd_shift[WIDTH-1:0];
`else
  assign avg_d = next_sum[SW-1:LOG2_DEPTH];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FILLING;
      sum_q     <= '0;
      cnt_q     <= '0;
      avg_out   <= '0;
      avg_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      avg_valid <= sample_valid;
      if (sample_valid) begin
        sum_q   <= next_sum;
        avg_out <= avg_d;
        if (cnt_q != CNT_FULL) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    filled  = 1'b0;
    case (state_q)
      ST_FILLING: begin
        if (sample_valid && cnt_q == CNT_LAST) state_d = ST_RUNNING;
      end
      ST_RUNNING: begin
        filled = 1'b1;
      end
      default: state_d = ST_FILLING;
    endcase
  end

endmodule

// File: tb/tb_distance_averager.sv
// Directed bench for distance_averager with a reference window model and a
// scoreboard of expected averages; honours DISTANCE_AVERAGER_ROUND_EN.
module tb_distance_averager;

  localparam int WIDTH = 13;
  localparam int DEPTH = 16;
  localparam int MAXV  = 8191;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             sample_valid = 1'b0;
  logic [WIDTH-1:0] sample_in = '0;
  logic [WIDTH-1:0] avg_out;
  logic             avg_valid;
  logic             filled;

  int checks   = 0;
  int failures = 0;

  int m_buf [DEPTH];
  int m_ptr, m_sum, m_cnt, m_avg;
  int exp_q [$];

  distance_averager dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .avg_out      (avg_out),
    .avg_valid    (avg_valid),
    .filled       (filled)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_buf[i] = 0;
    m_ptr = 0;
    m_sum = 0;
    m_cnt = 0;
    m_avg = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input int d);
    int r;
    m_sum = m_sum + d - m_buf[m_ptr];
    m_buf[m_ptr] = d;
    m_ptr = (m_ptr + 1) % DEPTH;
    if (m_cnt < DEPTH) m_cnt++;
`ifdef DISTANCE_AVERAGER_ROUND_EN
    r = (m_sum + DEPTH / 2) / DEPTH;
    if (r > MAXV) r = MAXV;
`else
    r = m_sum / DEPTH;
`endif
    exp_q.push_back(r);
  endtask

  // One clock: drive on the falling edge, check 1 time unit after the rising edge.
  task automatic step(input logic v, input int d, input logic rst);
    @(negedge clk);
    reset        = rst;
    sample_valid = v;
    sample_in    = WIDTH'(d);
    if (rst) model_reset();
    else if (v) model_accept(d);
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      m_avg = exp_q.pop_front();
      check("avg_valid_pulse", {31'b0, avg_valid}, 32'd1);
    end else begin
      check("avg_valid_idle", {31'b0, avg_valid}, 32'd0);
    end
    check("avg_out", {19'b0, avg_out}, m_avg);
    check("filled", {31'b0, filled}, (m_cnt == DEPTH) ? 32'd1 : 32'd0);
  endtask

  initial begin
    model_reset();
    step(1'b0, 0, 1'b1);
    step(1'b1, 500, 1'b1);

    for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b0);

    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 1600, 1'b0);
      check("ramp_1600", {19'b0, avg_out}, 100 * k);
    end
    check("filled_after_16", {31'b0, filled}, 32'd1);

    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b1, 0, 1'b0);
    check("single_zero", {19'b0, avg_out}, 32'd1500);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    check("hold_1500", {19'b0, avg_out}, 32'd1500);

    for (int i = 0; i < 40; i++) begin
      step(1'b1, (i % 2 == 0) ? 0 : 3200, 1'b0);
      if (i >= 15) check("alt_1600", {19'b0, avg_out}, 32'd1600);
    end

    for (int i = 0; i < 16; i++) step(1'b1, MAXV, 1'b0);
    check("all_max", {19'b0, avg_out}, MAXV);

    for (int i = 0; i < 5; i++) step(1'b1, 800, 1'b0);
    step(1'b1, 800, 1'b1);
    check("reset_avg", {19'b0, avg_out}, 32'd0);
    check("reset_filled", {31'b0, filled}, 32'd0);
    step(1'b1, 160, 1'b0);
    check("post_reset_160", {19'b0, avg_out}, 32'd10);

    step(1'b0, 0, 1'b1);
    step(1'b1, 8, 1'b0);
`ifdef DISTANCE_AVERAGER_ROUND_EN
    check("round_8", {19'b0, avg_out}, 32'd1);
`else
    check("trunc_8", {19'b0, avg_out}, 32'd0);
`endif
    step(1'b0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/distance_averager.md
Name: distance_averager

Overview:
Moving-average filter placed directly upstream of the distance-to-PWM duty-cycle stage. It accepts raw distance samples (unsigned, units of 10^-2 cm) with a valid strobe. It keeps the last 2^LOG2_DEPTH samples in a ring buffer and a running sum. It outputs the windowed mean plus a one-cycle update strobe, which is intended to drive the downstream converter's distance input and enable.

Parameters:
WIDTH, 13, bit width of distance samples and of the averaged output
LOG2_DEPTH, 4, log2 of window length; DEPTH = 2**LOG2_DEPTH (16 by default); legal range 1..6

Ports:
clk  input  1  system clock; all logic is on the rising edge
reset  input  1  one clock; reset is synchronous and active-high
sample_valid  input  1  sample_in is accepted on any rising edge where this is high
sample_in  input  WIDTH  raw distance sample
avg_out  output  WIDTH  current window mean; held between updates
avg_valid  output  1  one-cycle pulse, high in the cycle after each accepted sample
filled  output  1  high once DEPTH samples have been accepted since reset; sticky

Behaviour:
- Reset (reset=1 at an edge):
  - all buffer entries = 0; wr_ptr = 0; sum = 0; fill count = 0.
  - avg_out = 0, avg_valid = 0, filled = 0.
  - Reset dominates: sample_valid is ignored in any reset cycle.
  - Reset mid-stream discards all history and behaves identically to power-on reset.
- Internal state:
  - buf[0..DEPTH-1], each WIDTH bits.
  - wr_ptr, LOG2_DEPTH bits; wraps from DEPTH-1 to 0 with no special case.
  - sum, WIDTH+LOG2_DEPTH bits; never overflows, because max sum = DEPTH*(2^WIDTH-1).
  - cnt, LOG2_DEPTH+1 bits; saturates at DEPTH.
- Two-state FSM:
  - FILLING: cnt < DEPTH, filled=0.
  - RUNNING: filled=1.
  - FILLING -> RUNNING on the edge that accepts the DEPTH-th sample.
  - RUNNING is left only via reset.
- Accept edge (sample_valid=1, reset=0):
  - next_sum = sum + sample_in - buf[wr_ptr] (buf[wr_ptr] is the oldest sample; it is 0 while filling).
  - buf[wr_ptr] <= sample_in.
  - wr_ptr <= wr_ptr+1.
  - sum <= next_sum.
  - avg_out <= next_sum >> LOG2_DEPTH (truncating), cut to WIDTH bits with no loss.
  - avg_valid <= 1.
- Non-accept edge: avg_valid <= 0; everything else holds.
- Latency: a sample accepted at edge N is reflected in avg_out and avg_valid immediately after edge N (1 cycle).
- Throughput: back-to-back sample_valid every cycle is fully supported.
- Averaging while filling: the divisor is always DEPTH, so avg_out ramps up from 0 (the empty slots count as zero). Downstream may qualify with filled.
- All arithmetic is unsigned. The subtraction is done at sum width; the result is always >= 0.

Optional Feature:
Macro: DISTANCE_AVERAGER_ROUND_EN.
- Defined: avg_out = (next_sum + 2**(LOG2_DEPTH-1)) >> LOG2_DEPTH, i.e. round-half-up.
  - The addition is done at WIDTH+LOG2_DEPTH+1 bits.
  - The result is saturated to 2^WIDTH-1. Saturation can only trigger when all samples are at max, and the result is then exact.
- Undefined: plain truncation, as described in Behaviour.
- Latency and the strobes are identical in both builds.

Decomposition:
- Shared package distance_pkg:
  - DIST_WIDTH = 13.
  - DIST_MAX_CM100 = 3000 (saturation point of the downstream PWM stage).
  - typedef distance_t as logic [DIST_WIDTH-1:0].
- The module's WIDTH default references DIST_WIDTH.
- One natural sub-module, distance_ring_buffer. It holds the sync-reset register array and wr_ptr, provides a write port and a read-oldest port, and is combinational on the read side. The running sum, FSM and output registers stay in the top.

Test Plan (default parameters unless noted):
- Reset, then idle 5 cycles -> avg_out=0, avg_valid=0, filled=0 throughout.
- 16 back-to-back samples of 1600 -> after the k-th sample avg_out=100*k; avg_valid high for 16 consecutive cycles; filled rises after the 16th sample; final avg_out=1600.
- Continuing from the previous scenario, one sample of 0 with gaps either side -> avg_out=1500; avg_valid pulses exactly one cycle; avg_out holds 1500 during the gaps.
- 40 samples alternating 0/3200 -> from the 16th sample onward avg_out=1600 every update; wr_ptr wraps twice with no glitch.
- 16 samples of 8191 -> avg_out=8191, with no overflow in either build.
- Reset asserted after 5 samples of 800 while sample_valid=1, then 1 sample of 160 -> reset cycle: avg_out=0, filled=0; after the next sample: avg_out=10.
  - Rounding check: with DISTANCE_AVERAGER_ROUND_EN defined, a single sample of 8 after reset -> avg_out=1; the undefined build gives 0.
